// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing for the sequential divider
package div_pkg;

  localparam int DEF_N = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // counter must reach N, so it needs clog2(N+1) bits
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_N);

endpackage

// File: rtl/div_sub_step.sv
// rtl/div_sub_step.sv - (W)-bit ripple trial subtract a - b, nonneg when a >= b
module div_sub_step
  import div_pkg::*;
#(
  parameter int W = DEF_N + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         nonneg
);

  logic carry;

  // a + ~b + 1; final carry-out set means no borrow
  always_comb begin
    carry = 1'b1;
    diff  = '0;
    for (int i = 0; i < W; i++) begin
      diff[i] = a[i] ^ ~b[i] ^ carry;
      carry   = (a[i] & ~b[i]) | (carry & (a[i] ^ ~b[i]));
    end
    nonneg = carry;
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring divider, one quotient bit per cycle
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         signed_op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_t   state;
  logic [CW-1:0] cnt;
  logic [N-1:0] prem;
  logic [N-1:0] qreg;
  logic [N-1:0] dmag;
  logic         neg_q;
  logic         neg_r;
  logic         dz;

  logic [N-1:0] dd_mag;
  logic [N-1:0] dv_mag;
  logic [N:0]   trial_a;
  logic [N:0]   diff;
  logic         nonneg;
  logic         unused_diff_msb;

  // most-negative stays as 2^(N-1) when read unsigned, which is the true magnitude
  assign dd_mag = (signed_op && dividend[N-1]) ? -dividend : dividend;
  assign dv_mag = (signed_op && divisor[N-1])  ? -divisor  : divisor;

  assign trial_a         = {prem, qreg[N-1]};
  assign unused_diff_msb = diff[N];

  div_sub_step #(.W(N + 1)) u_step (
    .a      (trial_a),
    .b      ({1'b0, dmag}),
    .diff   (diff),
    .nonneg (nonneg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      prem        <= '0;
      qreg        <= '0;
      dmag        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            dmag  <= dv_mag;
            neg_q <= signed_op & (dividend[N-1] ^ divisor[N-1]);
            neg_r <= signed_op & dividend[N-1];
            if (divisor == '0) begin
              // raw dividend parked in prem so it is returned untouched
              dz    <= 1'b1;
              prem  <= dividend;
              qreg  <= '1;
              state <= DONE;
            end else begin
              dz    <= 1'b0;
              prem  <= '0;
              qreg  <= dd_mag;
              state <= RUN;
            end
          end
        end
        RUN: begin
          prem <= nonneg ? diff[N-1:0] : trial_a[N-1:0];
          qreg <= {qreg[N-2:0], nonneg};
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) state <= DONE;
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= dz;
          if (dz) begin
            quotient  <= qreg;
            remainder <= prem;
          end else begin
            quotient  <= neg_q ? -qreg : qreg;
            remainder <= neg_r ? -prem : prem;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider with random operands
module tb_seq_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_op;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t scoreboard[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: plain SV arithmetic, which truncates toward zero like the spec requires
  function automatic exp_t model(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sbv;
    sa = a;
    sbv = b;
    e.dz = 1'b0;
    e.cyc = 0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (!s) begin
      e.q = a / b; e.r = a % b;
    end else if (a == {1'b1, {(N-1){1'b0}}} && b == '1) begin
      e.q = a; e.r = '0;
    end else begin
      e.q = sa / sbv; e.r = sa % sbv;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      chk("done_single_pulse", {63'd0, prev_done}, 64'd0);
      if (scoreboard.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e = scoreboard.pop_front();
        chk("quotient", {32'd0, quotient}, {32'd0, e.q});
        chk("remainder", {32'd0, remainder}, {32'd0, e.r});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dz});
        chk("done_latency", 64'(cyc), 64'(e.cyc));
        chk("busy_low_at_done", {63'd0, busy}, 64'd0);
      end
    end
    prev_done = done;
  end

  task automatic issue(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit push, input logic [N-1:0] eq, input logic [N-1:0] er,
                       input logic edz);
    exp_t e;
    @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz;
      e.cyc = cyc + ((b == '0) ? 1 : N + 1);
      scoreboard.push_back(e);
    end
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    start = 1'b0;
    signed_op = 1'($urandom_range(0, 1));
    dividend = $urandom;
    divisor = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (scoreboard.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (scoreboard.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pending expected 0", scoreboard.size());
      scoreboard.delete();
    end
  endtask

  task automatic run_model(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t m;
    m = model(s, a, b);
    issue(s, a, b, 1'b1, m.q, m.r, m.dz);
    wait_done();
  endtask

  initial begin
    exp_t m;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         s;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_quotient", {32'd0, quotient}, 64'd0);
    chk("rst_remainder", {32'd0, remainder}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    rst = 1'b0;

    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0); wait_done();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0); wait_done();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0); wait_done();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0); wait_done();
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0); wait_done();
    issue(1'b0, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1); wait_done();
    issue(1'b1, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1); wait_done();

    // second start mid-run must vanish; results then hold
    issue(1'b0, 32'd1000, 32'd33, 1'b1, 32'd30, 32'd10, 1'b0);
    repeat (9) @(negedge clk);
    start = 1'b1; dividend = 32'd77; divisor = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    chk("hold_quotient", {32'd0, quotient}, 64'd30);
    chk("hold_remainder", {32'd0, remainder}, 64'd10);
    chk("hold_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("hold_busy", {63'd0, busy}, 64'd0);

    // reset during RUN aborts with no done
    issue(1'b0, 32'd5000, 32'd3, 1'b0, '0, '0, 1'b0);
    repeat (14) @(negedge clk);
    chk("busy_mid_run", {63'd0, busy}, 64'd1);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_quotient", {32'd0, quotient}, 64'd0);
    chk("abort_remainder", {32'd0, remainder}, 64'd0);
    chk("abort_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (N + 5) @(negedge clk);
    issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0); wait_done();

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: begin s = 1'b1; a = 32'h8000_0000; b = '1; end
        3: b = -b;
        default: ;
      endcase
      m = model(s, a, b);
      issue(s, a, b, 1'b1, m.q, m.r, m.dz);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
